// File: rtl/spell_io_arbiter_pkg.sv
// Shared definitions for the SPELL IO-port arbiter: register map, state encoding, defaults.
// Imported by the arbiter top and its round-robin picker.
package spell_io_pkg;

    localparam logic [7:0] REG_PIN  = 8'h36;
    localparam logic [7:0] REG_DDR  = 8'h37;
    localparam logic [7:0] REG_PORT = 8'h38;

    localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/spell_io_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the requester that did not win last time gets it.
// Kept generic so other shared peripherals can reuse it.
module spell_rr_arb2
    import spell_io_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       idx_o
);

    logic [1:0] cand;

    always_comb begin
        cand    = req_i & ~mask_i;
        valid_o = |cand;
        idx_o   = (cand == 2'b11) ? ~last_grant_i : cand[1];
    end

endmodule

// File: rtl/spell_io_arbiter.sv
// Arbitrates the single IO-register port between the SPELL core (0) and the debug/loader port (1),
// one transaction at a time, with a forced select-low cycle between transactions.
module spell_io_arbiter
    import spell_io_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 15,   // legal 2..255
    parameter logic [7:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [7:0] addr0_i,
    input  logic [7:0] addr1_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    input  logic       write0_i,
    input  logic       write1_i,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic [7:0] rdata0_o,
    output logic [7:0] rdata1_o,
    output logic       err0_o,
    output logic       err1_o,
    output logic       mem_select_o,
    output logic [7:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    output logic       mem_write_o,
    input  logic [7:0] mem_rdata_i,
    input  logic       mem_ready_i,
    output logic       busy_o,
    output logic       grant_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ack_q, ack_d;
    logic [1:0] err_q, err_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       sel_q, sel_d;
    logic [7:0] maddr_q, maddr_d;
    logic [7:0] mwdata_q, mwdata_d;
    logic       mwrite_q, mwrite_d;
    logic       busy_q, busy_d;

    logic [1:0] arb_mask;
    logic       arb_valid;
    logic       arb_idx;

    // The requester acked in GAP is still holding req this cycle, so keep it out of the pick.
    assign arb_mask = (state_q == GAP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

    spell_rr_arb2 u_arb (
        .req_i        ({req1_i, req0_i}),
        .mask_i       (arb_mask),
        .last_grant_i (last_grant_q),
        .valid_o      (arb_valid),
        .idx_o        (arb_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        ack_d        = 2'b00;
        err_d        = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        sel_d        = sel_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        mwrite_d     = mwrite_q;

        case (state_q)
            IDLE, GAP: begin
                if (arb_valid) begin
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                    maddr_d      = arb_idx ? addr1_i  : addr0_i;
                    mwdata_d     = arb_idx ? wdata1_i : wdata0_i;
                    mwrite_d     = arb_idx ? write1_i : write0_i;
                    sel_d        = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = BUSY;
                end else begin
                    sel_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    if (grant_q) rdata1_d = mem_rdata_i;
                    else         rdata0_d = mem_rdata_i;
                    ack_d[grant_q] = 1'b1;
                    sel_d          = 1'b0;
                    state_d        = GAP;
                end else if (cnt_q == CNT_LAST) begin
                    // A timed-out write leaves the requester's last read data untouched.
                    if (!mwrite_q) begin
                        if (grant_q) rdata1_d = ERR_DATA;
                        else         rdata0_d = ERR_DATA;
                    end
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = 1'b1;
                    sel_d          = 1'b0;
                    state_d        = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                sel_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= 8'd0;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            rdata0_q     <= 8'd0;
            rdata1_q     <= 8'd0;
            sel_q        <= 1'b0;
            maddr_q      <= 8'd0;
            mwdata_q     <= 8'd0;
            mwrite_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            sel_q        <= sel_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            mwrite_q     <= mwrite_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0_o       = ack_q[0];
    assign ack1_o       = ack_q[1];
    assign err0_o       = err_q[0];
    assign err1_o       = err_q[1];
    assign rdata0_o     = rdata0_q;
    assign rdata1_o     = rdata1_q;
    assign mem_select_o = sel_q;
    assign mem_addr_o   = maddr_q;
    assign mem_wdata_o  = mwdata_q;
    assign mem_write_o  = mwrite_q;
    assign busy_o       = busy_q;
    assign grant_o      = grant_q;

endmodule

// File: tb/tb_spell_io_arbiter.sv
// Scoreboard bench for spell_io_arbiter with a small behavioural IO register block
// (PIN/DDR/PORT, registered data_ready, edge-protected PIN toggle).
module tb_spell_io_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] wr = 2'b00;
    logic [7:0] addr [2];
    logic [7:0] wdata [2];
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       mem_select, mem_write, mem_ready, busy, grant;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    // IO block model state
    logic [7:0] port_m = 8'h00;
    logic [7:0] ddr_m = 8'h00;
    logic [7:0] dout_m = 8'h00;
    logic       rdy_m = 1'b0;
    logic       sel_prev = 1'b0;
    logic       rdy_en = 1'b1;
    logic       preload = 1'b0;
    logic [7:0] preload_val = 8'h00;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] rdata;
        bit         chk_rd;
        bit         err;
        int         cyc;
    } exp_t;

    exp_t q0 [$];
    exp_t q1 [$];
    int   glog [$];

    assign mem_ready = rdy_m;
    assign mem_rdata = dout_m;

    spell_io_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_i       (req[0]),
        .req1_i       (req[1]),
        .addr0_i      (addr[0]),
        .addr1_i      (addr[1]),
        .wdata0_i     (wdata[0]),
        .wdata1_i     (wdata[1]),
        .write0_i     (wr[0]),
        .write1_i     (wr[1]),
        .ack0_o       (ack0),
        .ack1_o       (ack1),
        .rdata0_o     (rdata0),
        .rdata1_o     (rdata1),
        .err0_o       (err0),
        .err1_o       (err1),
        .mem_select_o (mem_select),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_write_o  (mem_write),
        .mem_rdata_i  (mem_rdata),
        .mem_ready_i  (mem_ready),
        .busy_o       (busy),
        .grant_o      (grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        sel_prev <= mem_select;
        rdy_m    <= rdy_en ? mem_select : 1'b0;
        case (mem_addr)
            8'h36:   dout_m <= 8'h00;
            8'h37:   dout_m <= ddr_m;
            8'h38:   dout_m <= port_m;
            default: dout_m <= 8'h00;
        endcase
        if (preload) begin
            port_m <= preload_val;
        end else if (mem_select && mem_write) begin
            case (mem_addr)
                8'h37:   ddr_m <= mem_wdata;
                8'h38:   port_m <= mem_wdata;
                8'h36:   if (!sel_prev) port_m <= port_m ^ mem_wdata;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, int'({ack0, ack1, err0, err1, mem_select, mem_write, busy, grant}), 0);
        chk({tag, "_rdata"}, int'({rdata1, rdata0}), 0);
        chk({tag, "_bus"}, int'({mem_addr, mem_wdata}), 0);
    endtask

    // Monitor: every ack pops the matching requester's expectation.
    exp_t me;
    int   mi;
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            mi = ack1 ? 1 : 0;
            chk("ack_exclusive", int'(ack0 && ack1), 0);
            chk("select_low_in_ack", int'(mem_select), 0);
            chk("grant_at_ack", int'(grant), mi);
            glog.push_back(mi);
            if ((mi == 0 && q0.size() == 0) || (mi == 1 && q1.size() == 0)) begin
                chk("unexpected_ack", mi, -1);
            end else begin
                me = (mi == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("ack%0d_cycle", mi), cyc, me.cyc);
                chk($sformatf("err%0d", mi), int'(mi ? err1 : err0), int'(me.err));
                if (me.chk_rd) chk($sformatf("rdata%0d", mi), int'(mi ? rdata1 : rdata0), int'(me.rdata));
            end
        end else if (err0 || err1) begin
            chk("err_without_ack", int'({err1, err0}), 0);
        end
    end

    // Issue one transaction from requester idx; caller is aligned just after a clock edge.
    task automatic txn(input int idx, input logic [7:0] a, input logic [7:0] wd, input logic w,
                       input logic [7:0] erd, input bit chk_rd, input bit eerr, input int lat,
                       input bit keep);
        exp_t e;
        int   n;
        req[idx]   = 1'b1;
        addr[idx]  = a;
        wdata[idx] = wd;
        wr[idx]    = w;
        e.rdata = erd; e.chk_rd = chk_rd; e.err = eerr; e.cyc = cyc + lat;
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((idx == 0) ? ack0 : ack1) && n < 60);
        if (!((idx == 0) ? ack0 : ack1)) chk($sformatf("ack%0d_wait", idx), 0, 1);
        @(posedge clk); #1;
        if (!keep) req[idx] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        addr[0] = 8'h00; addr[1] = 8'h00; wdata[0] = 8'h00; wdata[1] = 8'h00;
        @(posedge clk); #1;
        do_reset();
        check_zero("reset");

        preload_val = 8'h5A; preload = 1'b1;
        @(posedge clk); #1 preload = 1'b0;

        // Single read of PORT
        fork
            txn(0, 8'h38, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 3, 1'b0);
            begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("rd_select_c%0d", k), int'(mem_select), (k == 1 || k == 2) ? 1 : 0);
                    @(posedge clk); #1;
                end
            end
        join

        // Simultaneous writes after reset: requester 0 wins the first tie
        do_reset();
        fork
            txn(0, 8'h38, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 3, 1'b0);
            txn(1, 8'h38, 8'h22, 1'b1, 8'h00, 1'b0, 1'b0, 6, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 chk("gap_select_c3", int'(mem_select), 0);
                @(posedge clk);
                #1 chk("gap_select_c4", int'(mem_select), 1);
            end
        join
        chk("port_after_sim", int'(port_m), 8'h22);

        // Back-to-back PIN toggles must each land once
        fork
            txn(0, 8'h36, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0, 3, 1'b0);
            txn(1, 8'h36, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0, 6, 1'b0);
            begin
                int  toggles;
                logic prev;
                toggles = 0;
                prev = port_m[0];
                repeat (10) begin
                    @(negedge clk);
                    if (port_m[0] != prev) toggles++;
                    prev = port_m[0];
                end
                chk("pin_toggle_count", toggles, 2);
            end
        join
        chk("port_after_pin", int'(port_m), 8'h22);

        // Timeout on a read of DDR with data_ready stuck low
        rdy_en = 1'b0;
        txn(1, 8'h37, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 16, 1'b0);
        rdy_en = 1'b1;

        // Fairness with both requests held continuously
        do_reset();
        glog.delete();
        fork
            begin
                txn(0, 8'h37, 8'hA0, 1'b1, 8'h00, 1'b0, 1'b0, 3, 1'b1);
                txn(0, 8'h37, 8'hA1, 1'b1, 8'h00, 1'b0, 1'b0, 5, 1'b1);
                txn(0, 8'h37, 8'hA2, 1'b1, 8'h00, 1'b0, 1'b0, 5, 1'b0);
            end
            begin
                txn(1, 8'h37, 8'hB0, 1'b1, 8'h00, 1'b0, 1'b0, 6, 1'b1);
                txn(1, 8'h37, 8'hB1, 1'b1, 8'h00, 1'b0, 1'b0, 5, 1'b1);
                txn(1, 8'h37, 8'hB2, 1'b1, 8'h00, 1'b0, 1'b0, 5, 1'b0);
            end
        join
        chk("fair_count", glog.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fair_grant_%0d", k), (k < glog.size()) ? glog[k] : -1, k % 2);
        end

        // Reset in the middle of a read, then a clean read
        req[0] = 1'b1; addr[0] = 8'h38; wr[0] = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_select_c1", int'(mem_select), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero("rst_mid");
        rst_n = 1'b1;
        req[0] = 1'b0;
        txn(0, 8'h38, 8'h00, 1'b0, 8'h22, 1'b1, 1'b0, 3, 1'b0);

        repeat (3) @(posedge clk);
        chk("q0_leftover", q0.size(), 0);
        chk("q1_leftover", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1, "watchdog");
    end

endmodule
